seq_mult_controller: RTL and testbench
======================================

// Module: seq_mult_controller
// PURPOSE
// Control FSM for the shift-add sequential multiplier. It sits directly upstream of the
// multiplier datapath and drives its operand-load, running-sum clear, load and shift-right
// strobes. It examines the datapath's multiplier register one bit per step and runs the
// start/ready/done handshake with the system.
// PARAMETERS
// WIDTH    32    operand width; datapath multiplier/multiplicand width; counter is $clog2(WIDTH) bits
// PORTS
// clk_i       in   1      clock, all state on rising edge
// rst_n_i     in   1      synchronous active-low reset
// start_i     in   1      request a multiply; sampled only when ready_o=1
// mr_i        in   WIDTH  multiplier register contents from datapath (mr_o)
// ready_o     out  1      FSM idle; start_i accepted this cycle
// mr_ld_o     out  1      load datapath multiplier register
// md_ld_o     out  1      load datapath multiplicand register
// rs_clear_o  out  1      clear 2*WIDTH running-sum register
// rs_load_o   out  1      write adder sum into running-sum upper half
// rs_shr_o    out  1      shift running-sum right by 1
// done_o      out  1      one-cycle pulse: product valid on datapath product_o
// BEHAVIOUR
// - Reset: rst_n_i low at a rising edge -> state IDLE, bit counter 0; takes priority over all
//   else, including mid-operation (run aborted, no done_o). After reset: ready_o=1, all other outputs 0.
// - Outputs decoded combinationally from state (+ mr_i[cnt] in EXAM); not registered.
// - States/transitions:
//   IDLE : ready_o=1. start_i=1 -> LOAD, else stay.
//   LOAD : mr_ld_o=md_ld_o=rs_clear_o=1; cnt<=0 -> EXAM.
//   EXAM : mr_i[cnt]=1 -> rs_load_o=1, go SHIFT.
//          mr_i[cnt]=0 -> rs_shr_o=1; cnt==WIDTH-1 -> DONE, else cnt<=cnt+1, stay EXAM.
//   SHIFT: rs_shr_o=1; cnt==WIDTH-1 -> DONE, else cnt<=cnt+1 -> EXAM.
//   DONE : done_o=1 for exactly one cycle -> IDLE.
// - mr_i is read only in EXAM. Datapath registers load at the end of LOAD, so mr_i is
//   valid from the first EXAM cycle.
// - At most one of rs_clear_o/rs_load_o/rs_shr_o is high in any cycle. Datapath priority
//   is never relied on.
// - Per run: exactly WIDTH rs_shr_o cycles and popcount(mr) rs_load_o cycles.
//   Each rs_load_o cycle is immediately followed by an rs_shr_o cycle.
// - Latency: start_i sampled in cycle 0 -> LOAD in cycle 1 -> done_o in cycle
//   2+WIDTH+popcount(mr). WIDTH=32 range: 34..66.
// - start_i is ignored outside IDLE (no queueing). Back-to-back runs: DONE -> IDLE
//   (ready_o=1) -> LOAD, so at least one idle cycle between runs.
// - cnt never exceeds WIDTH-1; no wrap-around.
// - Unreachable state encodings -> IDLE on the next edge.
// TESTING
// 1 mr=0, WIDTH=32, start pulse cycle 0 -> LOAD strobes (mr_ld,md_ld,rs_clear) cycle 1;
//   rs_shr cycles 2..33; no rs_load; done_o cycle 34; ready_o=1 cycle 35.
// 2 mr=32'hFFFF_FFFF -> rs_load/rs_shr alternate cycles 2..65; 32 of each; done_o cycle 66.
// 3 mr=32'h8000_0001 -> rs_load in cycles 2 and 34; rs_shr in cycles 3..33 and 35; done_o cycle 36.
// 4 rst_n_i low in cycle 10 of a run with mr=32'hFFFF_FFFF -> next cycle ready_o=1, all strobes 0;
//   done_o never pulses; a fresh start then completes normally.
// 5 start_i held high throughout -> start ignored while busy; done_o, then one IDLE cycle
//   (ready_o=1), then LOAD; second run identical to first.
// 6 WIDTH=4, 200 random mr with a datapath model connected -> product_o == md*mr whenever
//   done_o=1; rs_shr count == 4, rs_load count == popcount(mr); never two rs_* strobes high together.

Source files
------------

// File: rtl/seq_mult_controller.sv
//-----------------------------------------------------------------------------
// seq_mult_controller
//
// Purpose:
//   Control FSM for a shift-add sequential multiplier. It drives the strobes
//   of the multiplier datapath that sits directly downstream of it:
//     - the operand loads,
//     - the running-sum clear,
//     - the running-sum load,
//     - the running-sum shift-right.
//   It inspects the datapath's multiplier register one bit per step. It also
//   runs the start/ready/done handshake with the surrounding system.
//
// Parameters:
//   WIDTH       operand width. The bit counter is $clog2(WIDTH) bits wide.
//
// Ports:
//   clk_i       clock; all state changes on the rising edge
//   rst_n_i     synchronous active-low reset
//   start_i     multiply request; sampled only while ready_o is high
//   mr_i        multiplier register contents coming back from the datapath
//   ready_o     controller idle; a start_i this cycle is accepted
//   mr_ld_o     load the datapath multiplier register
//   md_ld_o     load the datapath multiplicand register
//   rs_clear_o  clear the 2*WIDTH running-sum register
//   rs_load_o   write the adder sum into the upper half of the running sum
//   rs_shr_o    shift the running sum right by one
//   done_o      one-cycle pulse; the datapath product is valid
//-----------------------------------------------------------------------------
module seq_mult_controller #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] mr_i,
    output logic             ready_o,
    output logic             mr_ld_o,
    output logic             md_ld_o,
    output logic             rs_clear_o,
    output logic             rs_load_o,
    output logic             rs_shr_o,
    output logic             done_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_EXAM  = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_nextState;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_nextCnt;
    logic          w_mrBit;
    logic          w_lastBit;

    // The multiplier bit under examination and the "final bit" flag.
    // Together they decide whether a step adds before shifting and whether
    // this shift is the last one of the run.
    assign w_mrBit   = mr_i[r_cnt];
    assign w_lastBit = (r_cnt == LAST);

    // State register and bit counter.
    // Reset wins over everything, including a run in progress, which is
    // simply abandoned without a done pulse.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
        end
    end

    // Next-state and counter logic.
    // The counter advances only on a step's closing shift, and never past the
    // final bit; a run therefore shifts exactly WIDTH times. Any illegal
    // encoding recovers to idle on the next edge.
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_nextState = S_LOAD;
                end
            end
            S_LOAD: begin
                w_nextCnt   = '0;
                w_nextState = S_EXAM;
            end
            S_EXAM: begin
                if (w_mrBit) begin
                    w_nextState = S_SHIFT;
                end else if (w_lastBit) begin
                    w_nextState = S_DONE;
                end else begin
                    w_nextCnt = r_cnt + CW'(1);
                end
            end
            S_SHIFT: begin
                if (w_lastBit) begin
                    w_nextState = S_DONE;
                end else begin
                    w_nextCnt   = r_cnt + CW'(1);
                    w_nextState = S_EXAM;
                end
            end
            S_DONE: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
                w_nextCnt   = '0;
            end
        endcase
    end

    // Output decode.
    // Outputs are purely combinational from the state, plus the examined
    // multiplier bit while in EXAM. Each state raises at most one running-sum
    // strobe, so the datapath never has to arbitrate between clear, load and
    // shift.
    always_comb begin
        ready_o    = 1'b0;
        mr_ld_o    = 1'b0;
        md_ld_o    = 1'b0;
        rs_clear_o = 1'b0;
        rs_load_o  = 1'b0;
        rs_shr_o   = 1'b0;
        done_o     = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready_o = 1'b1;
            end
            S_LOAD: begin
                mr_ld_o    = 1'b1;
                md_ld_o    = 1'b1;
                rs_clear_o = 1'b1;
            end
            S_EXAM: begin
                if (w_mrBit) begin
                    rs_load_o = 1'b1;
                end else begin
                    rs_shr_o = 1'b1;
                end
            end
            S_SHIFT: begin
                rs_shr_o = 1'b1;
            end
            S_DONE: begin
                done_o = 1'b1;
            end
            default: begin
                ready_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_mult_controller.sv
//-----------------------------------------------------------------------------
// tb_seq_mult_controller
//
// Directed bench for seq_mult_controller.
//
// A WIDTH=32 instance is driven with hand-picked multiplier values, and each
// run's cycle-by-cycle strobe maps are compared against hand-derived tables.
//
// A WIDTH=4 instance is wired to a small shift-add datapath model, so that
// the product can be checked against md*mr.
//-----------------------------------------------------------------------------
module tb_seq_mult_controller;

    logic        clk;
    logic        rstN;
    logic        start;
    logic [31:0] mr;
    logic        ready, mrLd, mdLd, rsClear, rsLoad, rsShr, done;

    logic        start4;
    logic [3:0]  mrReg4;
    logic [3:0]  mdReg4;
    logic [3:0]  mrIn4;
    logic [3:0]  mdIn4;
    logic [7:0]  rs4;
    logic        carry4;
    logic        ready4, mrLd4, mdLd4, rsClear4, rsLoad4, rsShr4, done4;

    int nCompared   = 0;
    int nMismatched = 0;

    seq_mult_controller #(.WIDTH(32)) dut (
        .clk_i      (clk),
        .rst_n_i    (rstN),
        .start_i    (start),
        .mr_i       (mr),
        .ready_o    (ready),
        .mr_ld_o    (mrLd),
        .md_ld_o    (mdLd),
        .rs_clear_o (rsClear),
        .rs_load_o  (rsLoad),
        .rs_shr_o   (rsShr),
        .done_o     (done)
    );

    seq_mult_controller #(.WIDTH(4)) dut4 (
        .clk_i      (clk),
        .rst_n_i    (rstN),
        .start_i    (start4),
        .mr_i       (mrReg4),
        .ready_o    (ready4),
        .mr_ld_o    (mrLd4),
        .md_ld_o    (mdLd4),
        .rs_clear_o (rsClear4),
        .rs_load_o  (rsLoad4),
        .rs_shr_o   (rsShr4),
        .done_o     (done4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Shift-add datapath model for the 4-bit instance.
    // The adder carry is kept in its own bit so the following shift can
    // bring it into the top of the running sum.
    always @(posedge clk) begin
        if (mrLd4) mrReg4 <= mrIn4;
        if (mdLd4) mdReg4 <= mdIn4;
        if (rsClear4) begin
            rs4    <= 8'd0;
            carry4 <= 1'b0;
        end else if (rsLoad4) begin
            {carry4, rs4[7:4]} <= {1'b0, rs4[7:4]} + {1'b0, mdReg4};
        end else if (rsShr4) begin
            rs4    <= {carry4, rs4[7:1]};
            carry4 <= 1'b0;
        end
    end

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] mrVal, input logic startVal);
        mr    = mrVal;
        start = startVal;
    endtask

    function automatic logic [127:0] spanMap(input int lo, input int hi, input int step);
        logic [127:0] m;
        m = '0;
        for (int i = lo; i <= hi; i += step) m[i] = 1'b1;
        return m;
    endfunction

    // Starts a run in the current (idle) cycle, which is cycle 0. It records
    // which cycles carry rs_load and rs_shr, and returns at the negedge of the
    // done cycle, or after a bounded number of cycles.
    task automatic runOp(input logic [31:0] mrVal, input logic hold,
                         output int doneCyc, output logic [127:0] ldMap,
                         output logic [127:0] shrMap, output int overlap,
                         output logic loadOk);
        applyStimulus(mrVal, 1'b1);
        ldMap   = '0;
        shrMap  = '0;
        overlap = 0;
        doneCyc = -1;
        loadOk  = 1'b0;
        for (int c = 1; c < 100 && doneCyc < 0; c++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (c == 1) loadOk = mrLd & mdLd & rsClear & ~rsLoad & ~rsShr & ~ready & ~done;
            ldMap[c]  = rsLoad;
            shrMap[c] = rsShr;
            if (int'(rsClear) + int'(rsLoad) + int'(rsShr) > 1) overlap++;
            if (done) doneCyc = c;
        end
    endtask

    task automatic directedRun(input string name, input logic [31:0] mrVal,
                               input logic hold, input int expDone,
                               input logic [127:0] expLd, input logic [127:0] expShr);
        int           doneCyc;
        int           overlap;
        logic [127:0] ldMap;
        logic [127:0] shrMap;
        logic         loadOk;
        runOp(mrVal, hold, doneCyc, ldMap, shrMap, overlap, loadOk);
        checkOutput({name, "_loadStrobes"}, loadOk, 1'b1);
        checkOutput({name, "_doneCycle"}, doneCyc, expDone);
        checkOutput({name, "_rsLoadMap"}, ldMap, expLd);
        checkOutput({name, "_rsShrMap"}, shrMap, expShr);
        checkOutput({name, "_overlap"}, overlap, 0);
        @(negedge clk);
        checkOutput({name, "_readyAfter"}, ready, 1'b1);
        checkOutput({name, "_doneOnePulse"}, done, 1'b0);
    endtask

    // One WIDTH=4 run with random operands through the datapath model.
    task automatic run4();
        int         nShr;
        int         nLd;
        int         nOver;
        int         cyc;
        logic [7:0] expProd;
        logic       seen;
        mdIn4   = 4'($urandom_range(0, 15));
        mrIn4   = 4'($urandom_range(0, 15));
        expProd = {4'd0, mdIn4} * {4'd0, mrIn4};
        start4  = 1'b1;
        nShr    = 0;
        nLd     = 0;
        nOver   = 0;
        cyc     = 0;
        seen    = 1'b0;
        for (int c = 1; c < 20 && !seen; c++) begin
            @(negedge clk);
            start4 = 1'b0;
            if (rsShr4) nShr++;
            if (rsLoad4) nLd++;
            if (int'(rsClear4) + int'(rsLoad4) + int'(rsShr4) > 1) nOver++;
            if (done4) begin
                seen = 1'b1;
                cyc  = c;
                checkOutput("w4_product", rs4, expProd);
            end
        end
        checkOutput("w4_doneSeen", seen, 1'b1);
        checkOutput("w4_shrCount", nShr, 4);
        checkOutput("w4_ldCount", nLd, $countones(mrIn4));
        checkOutput("w4_overlap", nOver, 0);
        checkOutput("w4_latency", cyc, 6 + $countones(mrIn4));
        @(negedge clk);
    endtask

    initial begin
        int doneCount;
        rstN   = 1'b0;
        start4 = 1'b0;
        mrIn4  = 4'd0;
        mdIn4  = 4'd0;
        applyStimulus(32'd0, 1'b0);
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("rst_ready", ready, 1'b1);
        checkOutput("rst_strobes", {mrLd, mdLd, rsClear, rsLoad, rsShr, done}, 6'b0);
        checkOutput("rst_ready4", ready4, 1'b1);

        $display("[TB] mr=0");
        directedRun("zero", 32'h0000_0000, 1'b0, 34, '0, spanMap(2, 33, 1));

        $display("[TB] mr=all ones");
        directedRun("ones", 32'hFFFF_FFFF, 1'b0, 66, spanMap(2, 64, 2), spanMap(3, 65, 2));

        $display("[TB] mr=8000_0001");
        directedRun("ends", 32'h8000_0001, 1'b0, 36,
                    spanMap(2, 2, 1) | spanMap(34, 34, 1),
                    spanMap(3, 33, 1) | spanMap(35, 35, 1));

        $display("[TB] reset mid-run");
        applyStimulus(32'hFFFF_FFFF, 1'b1);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 10) rstN = 1'b0;
        end
        @(negedge clk);
        rstN = 1'b1;
        checkOutput("abort_ready", ready, 1'b1);
        checkOutput("abort_strobes", {mrLd, mdLd, rsClear, rsLoad, rsShr, done}, 6'b0);
        doneCount = 0;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            if (done) doneCount++;
        end
        checkOutput("abort_noDone", doneCount, 0);
        directedRun("afterAbort", 32'hFFFF_FFFF, 1'b0, 66, spanMap(2, 64, 2), spanMap(3, 65, 2));

        $display("[TB] start held high");
        directedRun("hold1", 32'h0000_00F0, 1'b1, 38, spanMap(6, 12, 2),
                    spanMap(2, 5, 1) | spanMap(7, 13, 2) | spanMap(14, 37, 1));
        directedRun("hold2", 32'h0000_00F0, 1'b1, 38, spanMap(6, 12, 2),
                    spanMap(2, 5, 1) | spanMap(7, 13, 2) | spanMap(14, 37, 1));
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("hold_idle", ready, 1'b1);

        $display("[TB] WIDTH=4 random runs with datapath model");
        for (int n = 0; n < 200; n++) run4();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
